// File: rtl/nn_argmax_pkg.sv
// Shared types and helpers for the sequential argmax classifier stage.
package nn_argmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Most negative two's-complement value of width w, sign-extended to 128 bits.
  function automatic logic [127:0] min_signed(input int w);
    return ~((128'd1 << (w - 1)) - 128'd1);
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_cmp_select.sv
// Single compare/select step of the argmax scan (combinational).
// Tracks the runner-up value when NN_ARGMAX_MARGIN_EN is defined.
module nn_cmp_select #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 4
) (
  input  logic signed [DATA_W-1:0] cand_val_i,
  input  logic        [IDX_W-1:0]  cand_idx_i,
  input  logic signed [DATA_W-1:0] best_val_i,
  input  logic        [IDX_W-1:0]  best_idx_i,
`ifdef NN_ARGMAX_MARGIN_EN
  input  logic signed [DATA_W-1:0] second_val_i,
  output logic signed [DATA_W-1:0] second_val_o,
`endif
  output logic signed [DATA_W-1:0] best_val_o,
  output logic        [IDX_W-1:0]  best_idx_o
);

  // Strict greater-than so ties keep the earlier (lower) index.
  always_comb begin
    best_val_o = best_val_i;
    best_idx_o = best_idx_i;
`ifdef NN_ARGMAX_MARGIN_EN
    second_val_o = second_val_i;
`endif
    if (cand_val_i > best_val_i) begin
      best_val_o = cand_val_i;
      best_idx_o = cand_idx_i;
`ifdef NN_ARGMAX_MARGIN_EN
      second_val_o = best_val_i;
`endif
    end else begin
`ifdef NN_ARGMAX_MARGIN_EN
      if (cand_val_i > second_val_i) begin
        second_val_o = cand_val_i;
      end else begin
        second_val_o = second_val_i;
      end
`endif
    end
  end

endmodule

// File: rtl/nn_argmax_seq.sv
// Sequential argmax over the network logits: snapshot on start, one compare per cycle.
// Optional best-minus-second margin output when NN_ARGMAX_MARGIN_EN is defined.
module nn_argmax_seq
  import nn_argmax_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 64,
  parameter int IDX_W       = idx_width(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] logits [NUM_CLASSES],
  output logic                     busy,
  output logic                     done,
  output logic        [IDX_W-1:0]  class_idx,
`ifdef NN_ARGMAX_MARGIN_EN
  output logic        [DATA_W:0]   margin,
`endif
  output logic signed [DATA_W-1:0] max_logit
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e                   state_q, state_d;
  logic                     snap_load_s;
  logic signed [DATA_W-1:0] snap_q [NUM_CLASSES];
  logic        [IDX_W-1:0]  idx_q, idx_d;
  logic signed [DATA_W-1:0] best_val_q, best_val_d;
  logic        [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic        [IDX_W-1:0]  class_idx_q, class_idx_d;
  logic signed [DATA_W-1:0] max_logit_q, max_logit_d;
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] cmp_val_s;
  logic        [IDX_W-1:0]  cmp_idx_s;
`ifdef NN_ARGMAX_MARGIN_EN
  localparam logic [127:0]             MIN_FULL = min_signed(DATA_W);
  localparam logic signed [DATA_W-1:0] MIN_VAL  = MIN_FULL[DATA_W-1:0];
  logic signed [DATA_W-1:0] second_val_q, second_val_d, cmp_second_s;
  logic        [DATA_W:0]   margin_q, margin_d;
`endif

  nn_cmp_select #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .cand_val_i  (snap_q[idx_q]),
    .cand_idx_i  (idx_q),
    .best_val_i  (best_val_q),
    .best_idx_i  (best_idx_q),
`ifdef NN_ARGMAX_MARGIN_EN
    .second_val_i(second_val_q),
    .second_val_o(cmp_second_s),
`endif
    .best_val_o  (cmp_val_s),
    .best_idx_o  (cmp_idx_s)
  );

  // Next-state and datapath control; results are published on the edge entering DONE.
  always_comb begin
    state_d     = state_q;
    snap_load_s = 1'b0;
    idx_d       = idx_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_logit_d = max_logit_q;
    done_d      = 1'b0;
`ifdef NN_ARGMAX_MARGIN_EN
    second_val_d = second_val_q;
    margin_d     = margin_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_load_s = 1'b1;
          best_val_d  = logits[0];
          best_idx_d  = {IDX_W{1'b0}};
          idx_d       = IDX_W'(1);
`ifdef NN_ARGMAX_MARGIN_EN
          second_val_d = MIN_VAL;
`endif
          state_d     = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        best_val_d = cmp_val_s;
        best_idx_d = cmp_idx_s;
        idx_d      = idx_q + IDX_W'(1);
`ifdef NN_ARGMAX_MARGIN_EN
        second_val_d = cmp_second_s;
`endif
        if (idx_q == LAST_IDX) begin
          class_idx_d = cmp_idx_s;
          max_logit_d = cmp_val_s;
`ifdef NN_ARGMAX_MARGIN_EN
          margin_d = {cmp_val_s[DATA_W-1], cmp_val_s} - {cmp_second_s[DATA_W-1], cmp_second_s};
`endif
          state_d = ST_DONE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      best_val_q  <= {DATA_W{1'b0}};
      best_idx_q  <= {IDX_W{1'b0}};
      class_idx_q <= {IDX_W{1'b0}};
      max_logit_q <= {DATA_W{1'b0}};
      done_q      <= 1'b0;
`ifdef NN_ARGMAX_MARGIN_EN
      second_val_q <= {DATA_W{1'b0}};
      margin_q     <= {(DATA_W + 1){1'b0}};
`endif
      for (int i = 0; i < NUM_CLASSES; i++) begin
        snap_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_logit_q <= max_logit_d;
      done_q      <= done_d;
`ifdef NN_ARGMAX_MARGIN_EN
      second_val_q <= second_val_d;
      margin_q     <= margin_d;
`endif
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (snap_load_s) begin
          snap_q[i] <= logits[i];
        end else begin
          snap_q[i] <= snap_q[i];
        end
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign max_logit = max_logit_q;
`ifdef NN_ARGMAX_MARGIN_EN
  assign margin    = margin_q;
`endif

endmodule

// File: tb/tb_nn_argmax_seq.sv
// Self-checking bench for nn_argmax_seq: vector table, corner sequences, random vs. reference model.
module tb_nn_argmax_seq;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic signed [63:0] lg [10];
  logic               busy, done;
  logic        [3:0]  class_idx;
  logic signed [63:0] max_logit;
`ifdef NN_ARGMAX_MARGIN_EN
  logic        [64:0] margin;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [63:0] v [10];
    int                 idx;
    logic signed [63:0] val;
    logic        [64:0] mg;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  nn_argmax_seq dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .logits   (lg),
    .busy     (busy),
    .done     (done),
    .class_idx(class_idx),
`ifdef NN_ARGMAX_MARGIN_EN
    .margin   (margin),
`endif
    .max_logit(max_logit)
  );

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: argmax with lowest index on ties; margin = best minus max of the others.
  function automatic void model(input logic signed [63:0] v [10], output int bi,
                                output logic signed [63:0] bv, output logic [64:0] mg);
    logic signed [63:0] s;
    logic signed [64:0] a, b;
    bit first;
    bi = 0;
    bv = v[0];
    for (int i = 1; i < 10; i++) if (v[i] > bv) begin bv = v[i]; bi = i; end
    first = 1'b1;
    s = 64'sd0;
    for (int j = 0; j < 10; j++) begin
      if (j != bi && (first || v[j] > s)) begin s = v[j]; first = 1'b0; end
    end
    a = bv;
    b = s;
    mg = a - b;
  endfunction

  // Issue one request from the current lg contents (called at a negedge).
  task automatic run_req(input string nm, input int e_idx, input logic signed [63:0] e_val,
                         input logic [64:0] e_mg, input bit disturb);
    int busy_n, lat, dn;
    logic [3:0]         got_idx;
    logic signed [63:0] got_val;
    logic [64:0]        got_mg;
    got_idx = 4'd0; got_val = 64'sd0; got_mg = 65'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = busy ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      if (disturb && c == 4) begin
        start = 1'b1;
        for (int i = 0; i < 10; i++) lg[i] = {$urandom, $urandom};
      end
      if (disturb && c == 5) start = 1'b0;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = c;
        got_idx = class_idx;
        got_val = max_logit;
`ifdef NN_ARGMAX_MARGIN_EN
        got_mg = margin;
`endif
      end
    end
    check({nm, " latency"}, 65'(lat), 65'd10);
    check({nm, " busy_cycles"}, 65'(busy_n), 65'd10);
    check({nm, " class_idx"}, {61'd0, got_idx}, 65'(e_idx));
    check({nm, " max_logit"}, {1'b0, got_val}, {1'b0, e_val});
`ifdef NN_ARGMAX_MARGIN_EN
    check({nm, " margin"}, got_mg, e_mg);
`else
    if (got_mg != 65'd0 || e_mg == 65'd0) got_mg = 65'd0;
`endif
    if (disturb) begin
      dn = 0;
      start = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done || busy) dn++;
      end
      check({nm, " extra_activity"}, 65'(dn), 65'd0);
    end
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < 10; i++) lg[i] = tbl[k].v[i];
  endtask

  initial begin
    int                 ri, dn;
    logic signed [63:0] rv;
    logic [64:0]        rm;
    logic signed [63:0] snap [10];

    // Vector table: ramp, all-negative, tie, max at index 0, full-range, all equal.
    for (int i = 0; i < 10; i++) tbl[0].v[i] = 64'(i) <<< 16;
    tbl[0].idx = 9; tbl[0].val = 64'sh90000; tbl[0].mg = 65'h10000;
    for (int i = 0; i < 10; i++) tbl[1].v[i] = -(64'(i + 1) <<< 16);
    tbl[1].v[3] = -64'sh1000;
    tbl[1].idx = 3; tbl[1].val = -64'sd4096; tbl[1].mg = 65'hF000;
    for (int i = 0; i < 10; i++) tbl[2].v[i] = 64'(i) <<< 12;
    tbl[2].v[2] = 64'sh50000; tbl[2].v[7] = 64'sh50000;
    tbl[2].idx = 2; tbl[2].val = 64'sh50000; tbl[2].mg = 65'd0;
    for (int i = 0; i < 10; i++) tbl[3].v[i] = -64'(i);
    tbl[3].v[0] = 64'sd100;
    tbl[3].idx = 0; tbl[3].val = 64'sd100; tbl[3].mg = 65'd101;
    for (int i = 0; i < 10; i++) tbl[4].v[i] = 64'sh8000_0000_0000_0000;
    tbl[4].v[9] = 64'sh7FFF_FFFF_FFFF_FFFF;
    tbl[4].idx = 9; tbl[4].val = 64'sh7FFF_FFFF_FFFF_FFFF; tbl[4].mg = 65'h0_FFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) tbl[5].v[i] = -64'sd7;
    tbl[5].idx = 0; tbl[5].val = -64'sd7; tbl[5].mg = 65'd0;

    rstn = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) lg[i] = 64'sd0;
    #1;
    check("reset busy", {64'd0, busy}, 65'd0);
    check("reset done", {64'd0, done}, 65'd0);
    check("reset class_idx", {61'd0, class_idx}, 65'd0);
    check("reset max_logit", {1'b0, max_logit}, 65'd0);
`ifdef NN_ARGMAX_MARGIN_EN
    check("reset margin", margin, 65'd0);
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Table runs are issued back-to-back: each start lands in the previous done cycle.
    for (int k = 0; k < 6; k++) begin
      load_vec(k);
      run_req($sformatf("vec%0d", k), tbl[k].idx, tbl[k].val, tbl[k].mg, 1'b0);
    end

    load_vec(0);
    run_req("pre_reset", tbl[0].idx, tbl[0].val, tbl[0].mg, 1'b0);

    // Reset in the middle of a scan: outputs clear at once, no done pulse.
    load_vec(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midreset busy", {64'd0, busy}, 65'd0);
    check("midreset class_idx", {61'd0, class_idx}, 65'd0);
    check("midreset max_logit", {1'b0, max_logit}, 65'd0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midreset no_done", 65'(dn), 65'd0);
    run_req("post_reset", tbl[1].idx, tbl[1].val, tbl[1].mg, 1'b0);

    // Start during scan plus logits rewritten after the start edge.
    load_vec(2);
    run_req("snapshot", tbl[2].idx, tbl[2].val, tbl[2].mg, 1'b1);

    // Random requests against the reference model; even iterations use a narrow range for ties.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 10; i++) begin
        if (it % 2 == 0) lg[i] = 64'($urandom_range(0, 3)) - 64'sd2;
        else             lg[i] = {$urandom, $urandom};
        snap[i] = lg[i];
      end
      model(snap, ri, rv, rm);
      run_req($sformatf("rand%0d", it), ri, rv, rm, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
